// File: rtl/avl_mem_responder.sv
// Avalon-style memory responder: models a memory controller that needs an init
// period, stalls periodically and returns read data after a fixed latency.
module avl_mem_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int INIT_CYCLES  = 16,
  parameter int READ_LATENCY = 4,
  parameter int STALL_EVERY  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [25:0]  avl_address,
  input  logic [127:0] avl_writedata,
  input  logic         avl_write,
  input  logic         avl_read,
  input  logic         avl_burstbegin,
  output logic         local_init_done,
  output logic         avl_wait_request_n,
  output logic         avl_readdatavalid,
  output logic [127:0] avl_readdata,
  output logic         addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACW   = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam logic [ACW-1:0] STALL_LAST = ACW'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);
  localparam logic [9:0]     INIT_LAST  = 10'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {S_INIT, S_READY, S_STALL} state_e;

  state_e                state_q, state_d;
  logic [9:0]            init_cnt_q, init_cnt_d;
  logic [ACW-1:0]        acc_cnt_q, acc_cnt_d;
  logic                  accept, out_of_range, collision, do_write, do_read;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [127:0]          mem_q [DEPTH];
  logic [READ_LATENCY-1:0] rd_vld_q;
  logic [127:0]          rd_data_q [READ_LATENCY];
  logic                  rvalid_q;
  logic [127:0]          rdata_q;
  logic                  addr_err_q;
  logic                  unused_burstbegin;

  // Bursts are always single-beat, so the burst marker carries no information.
  assign unused_burstbegin  = avl_burstbegin;

  assign local_init_done    = (state_q != S_INIT);
  assign avl_wait_request_n = (state_q == S_READY);
  assign accept             = (avl_read | avl_write) & avl_wait_request_n & local_init_done;
  assign mem_addr           = avl_address[DEPTH_LOG2-1:0];
  assign out_of_range       = (avl_address >> DEPTH_LOG2) != '0;
  assign collision          = avl_read & avl_write;
  assign do_write           = accept & avl_write & ~avl_read;
  assign do_read            = accept & avl_read & ~avl_write;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_READY;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 10'd1;
        end
      end
      S_READY: begin
        if (accept) begin
          if ((STALL_EVERY != 0) && (acc_cnt_q == STALL_LAST)) begin
            acc_cnt_d = '0;
            state_d   = S_STALL;
          end else begin
            acc_cnt_d = acc_cnt_q + ACW'(1);
          end
        end
      end
      S_STALL: state_d = S_READY;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      acc_cnt_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      addr_err_q <= addr_err_q | (accept & (out_of_range | collision));
    end
  end

  // Memory is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[mem_addr] <= avl_writedata;
    end
  end

  // Data is captured at acceptance so later writes cannot leak into an older read.
  always_ff @(posedge clk) begin
    rd_data_q[0] <= mem_q[mem_addr];
    for (int k = 1; k < READ_LATENCY; k++) begin
      rd_data_q[k] <= rd_data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_vld_q <= {rd_vld_q[READ_LATENCY-2:0], do_read};
      rvalid_q <= rd_vld_q[READ_LATENCY-1];
      if (rd_vld_q[READ_LATENCY-1]) begin
        rdata_q <= rd_data_q[READ_LATENCY-1];
      end
    end
  end

  assign avl_readdatavalid = rvalid_q;
  assign avl_readdata      = rdata_q;
  assign addr_err          = addr_err_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Scoreboard bench for avl_mem_responder: directed commands push expected beats,
// an independent monitor pops and compares them as the DUT returns data.
module tb_avl_mem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [25:0]  avl_address = '0;
  logic [127:0] avl_writedata = '0;
  logic         avl_write = 1'b0;
  logic         avl_read = 1'b0;
  logic         avl_burstbegin = 1'b0;
  logic         local_init_done;
  logic         avl_wait_request_n;
  logic         avl_readdatavalid;
  logic [127:0] avl_readdata;
  logic         addr_err;

  avl_mem_responder #(
    .DEPTH_LOG2(10), .INIT_CYCLES(16), .READ_LATENCY(LAT), .STALL_EVERY(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_write(avl_write), .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
    .local_init_done(local_init_done), .avl_wait_request_n(avl_wait_request_n),
    .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sbQ[$];
  exp_t         popped;
  logic [127:0] lastData = '0;
  int           errors = 0;
  int           checks = 0;
  int           modelAcc = 0;
  bit           stallNext = 1'b0;

  localparam logic [127:0] D3 = 128'h0123456789ABCDEF_FEDCBA98765432A5;

  function automatic logic [127:0] pat(input int k);
    return {4{32'hA5000000 + 32'(k)}};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every beat must match the oldest expected entry and arrive on its due cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      lastData = '0;
    end else if (avl_readdatavalid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_beat", 128'd1, 128'd0);
      end else begin
        popped = sbQ.pop_front();
        checkOutput("beat_data", avl_readdata, popped.data);
        checkOutput("beat_cycle", 128'(cyc), 128'(popped.due));
        lastData = popped.data;
      end
    end else begin
      checkOutput("readdata_hold", avl_readdata, lastData);
    end
  end

  task automatic clearInputs();
    avl_read = 1'b0;
    avl_write = 1'b0;
    avl_burstbegin = 1'b0;
    avl_address = '0;
    avl_writedata = '0;
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [25:0] addr,
                               input logic [127:0] data, input bit expBeat,
                               input logic [127:0] expData);
    int n;
    n = 0;
    avl_read = rd;
    avl_write = wr;
    avl_address = addr;
    avl_writedata = data;
    avl_burstbegin = 1'b1;
    while (!avl_wait_request_n && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checkOutput("accept_timeout", 128'(n), 128'd0);
      clearInputs();
      return;
    end
    checkOutput("stall_cycles", 128'(n), stallNext ? 128'd1 : 128'd0);
    @(posedge clk);
    #1;
    if (expBeat) sbQ.push_back('{data: expData, due: cyc + LAT});
    modelAcc++;
    stallNext = (modelAcc % 4 == 0);
    @(negedge clk);
    clearInputs();
  endtask

  task automatic writeWord(input logic [25:0] addr, input logic [127:0] data);
    applyStimulus(1'b0, 1'b1, addr, data, 1'b0, '0);
  endtask

  task automatic readWord(input logic [25:0] addr, input logic [127:0] exp);
    applyStimulus(1'b1, 1'b0, addr, '0, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n > 0) stallNext = 1'b0;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    sbQ.delete();
    modelAcc = 0;
    stallNext = 1'b0;
    clearInputs();
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_init_done", 128'(local_init_done), 128'd0);
      checkOutput("rst_wait_n", 128'(avl_wait_request_n), 128'd0);
      checkOutput("rst_rvalid", 128'(avl_readdatavalid), 128'd0);
      checkOutput("rst_rdata", avl_readdata, 128'd0);
      checkOutput("rst_addr_err", 128'(addr_err), 128'd0);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checkOutput("init_done", 128'(local_init_done), (i == 16) ? 128'd1 : 128'd0);
      checkOutput("init_wait_n", 128'(avl_wait_request_n), (i == 16) ? 128'd1 : 128'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    applyReset();

    writeWord(26'd3, D3);
    readWord(26'd3, D3);
    writeWord(26'd0, pat(0));
    writeWord(26'd1, pat(1));
    for (int k = 0; k < 8; k++) writeWord(26'(16 + k), pat(16 + k));
    writeWord(26'd2, pat(2));
    readWord(26'd0, pat(0));
    readWord(26'd1, pat(1));
    readWord(26'd2, pat(2));
    for (int k = 0; k < 8; k++) readWord(26'(16 + k), pat(16 + k));
    idle(8);
    checkOutput("addr_err_clean", 128'(addr_err), 128'd0);

    // Out-of-range address aliases onto word 0; a read+write collision is dropped.
    readWord(26'h400, pat(0));
    checkOutput("addr_err_set", 128'(addr_err), 128'd1);
    applyStimulus(1'b1, 1'b1, 26'd3, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b0, '0);
    readWord(26'd3, D3);
    checkOutput("addr_err_sticky", 128'(addr_err), 128'd1);
    idle(10);
    checkOutput("queue_drained", 128'(sbQ.size()), 128'd0);

    // A read in flight at reset must never produce a beat.
    readWord(26'd0, pat(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    applyReset();
    idle(12);
    readWord(26'd3, D3);
    idle(8);
    checkOutput("final_drained", 128'(sbQ.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avl_mem_responder.md
AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, number of 128-bit words stored = 2**DEPTH_LOG2.
REQ-002 Parameter INIT_CYCLES, default 16, cycles after reset release before local_init_done rises; legal range 1..1023.
REQ-003 Parameter READ_LATENCY, default 4, cycles from read acceptance to avl_readdatavalid; legal range 2..8.
REQ-004 Parameter STALL_EVERY, default 4, accepted commands between forced one-cycle stalls; 0 disables stalls.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 avl_address  input  26  word address from the Master; bits [DEPTH_LOG2-1:0] index memory.
REQ-008 avl_writedata  input  128  write data.
REQ-009 avl_write  input  1  write request.
REQ-010 avl_read  input  1  read request.
REQ-011 avl_burstbegin  input  1  burst start marker; single-beat bursts only, ignored functionally.
REQ-012 local_init_done  output  1  memory ready.
REQ-013 avl_wait_request_n  output  1  high = command accepted this cycle.
REQ-014 avl_readdatavalid  output  1  avl_readdata valid this cycle.
REQ-015 avl_readdata  output  128  read data.
REQ-016 addr_err  output  1  sticky: high once an out-of-range or read+write collision command was presented.

Function
REQ-017 Command acceptance SHALL occur on a rising edge where (avl_read | avl_write) & avl_wait_request_n & local_init_done.
REQ-018 State machine SHALL have states INIT, READY, STALL; INIT entered on reset.
REQ-019 INIT: counter counts INIT_CYCLES cycles; local_init_done=0, avl_wait_request_n=0; then -> READY.
REQ-020 READY: avl_wait_request_n=1; local_init_done=1 in READY and STALL permanently until reset.
REQ-021 Accepted-command counter SHALL increment per acceptance; when it reaches STALL_EVERY it clears and FSM -> STALL for exactly one cycle (avl_wait_request_n=0), then -> READY.
REQ-022 Accepted write SHALL store avl_writedata at avl_address[DEPTH_LOG2-1:0] at that edge.
REQ-023 Accepted read SHALL drive avl_readdatavalid=1 with the word exactly READ_LATENCY cycles later, one beat, in acceptance order; back-to-back reads give back-to-back beats.
REQ-024 Read data SHALL reflect all writes accepted before the read, including a write in the immediately preceding cycle.
REQ-025 avl_address bits above DEPTH_LOG2-1 nonzero: command still accepted using low bits (aliasing), addr_err set.
REQ-026 avl_read & avl_write both high in an acceptance cycle: counted as accepted, neither memory write nor read beat performed, addr_err set.
REQ-027 avl_readdata SHALL hold its last value when avl_readdatavalid=0.
REQ-028 Commands presented while avl_wait_request_n=0 SHALL have no effect; Master must hold them.

Reset
REQ-029 On reset_n low, asynchronously: FSM=INIT, counters=0, local_init_done=0, avl_wait_request_n=0, avl_readdatavalid=0, avl_readdata=0, addr_err=0.
REQ-030 Reads in flight at reset SHALL be discarded; no avl_readdatavalid after reset release until a new read is accepted.
REQ-031 Memory contents SHALL NOT be cleared by reset and are unspecified at power-up.

Verification
REQ-032 Release reset, defaults -> local_init_done and avl_wait_request_n rise exactly 16 cycles after release; all outputs 0 before.
REQ-033 Write 0x...A5 to addr 3, next cycle read addr 3 -> avl_readdatavalid 4 cycles after read acceptance, avl_readdata=0x...A5.
REQ-034 Stream 8 writes held continuously -> avl_wait_request_n low for one cycle after 4th and 8th acceptance; all 8 words stored, none duplicated.
REQ-035 Read addrs 0,1,2 back-to-back after prior writes -> three consecutive valid beats in order, correct data.
REQ-036 Read at address 0x400 (DEPTH_LOG2=10) -> returns word at addr 0, addr_err=1; read+write together -> no beat, no store, addr_err stays 1.
REQ-037 Accept read, assert reset_n low 2 cycles later -> no avl_readdatavalid ever produced; init sequence repeats.
